jvm_param_emitter: RTL and testbench

Parametrised successor to the single-byte parameter push path of the JVM-to-ARM translator. Collects a JVM opcode's 1..MAX_BYTES immediate operand bytes (big-endian, as in the bytecode stream) and zero- or sign-extends them to 32 bits. Emits the ARM sequence that loads the value into register REG and pushes it onto the ARM stack. Sits between the bytecode byte fetcher (input) and the translated-instruction writer (output); the translator state machine drives it per opcode.

---
 rtl/jvm_param_emitter.sv | 221 ++++++++++++++++++++++
 tb/tb_jvm_param_emitter.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jvm_param_emitter.sv
// jvm_param_emitter
//   Collects the 1..MAX_BYTES big-endian immediate operand bytes of a JVM
//   opcode. It zero- or sign-extends them to 32 bits and emits the ARM words
//   that load the value into register REG and push it onto the ARM stack:
//   MOVW, then MOVT if needed, then STR Rd,[sp,#-4]!.
//
//   Optional feature: define MVN_SHORT_EN to emit a single MVN Rd,#imm8 in
//   place of MOVW/MOVT when the complement of the value fits in 8 bits.
//
// Ports
//   clk, reset            system clock; asynchronous active-high reset
//   start                 one-cycle request, sampled only in IDLE
//   byte_count            operand byte count (saturates at MAX_BYTES)
//   sign_ext              1 = sign-extend, 0 = zero-extend
//   busy, done            sequence in progress / one-cycle completion pulse
//   byte_valid/ready/data operand byte stream from the fetcher
//   inst_valid/ready/data ARM instruction stream to the writer
//
// State | meaning
//   IDLE      | waiting for start
//   COLLECT   | shifting in operand bytes
//   EMIT_LO   | MOVW (or MVN) word offered
//   EMIT_HI   | MOVT word offered
//   EMIT_PUSH | STR pre-decrement push offered
//   FINISH    | done pulse, back to IDLE

module jvm_param_emitter #(
  parameter int MAX_BYTES = 4,
  parameter int REG       = 0,
  parameter int CNT_W     = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] byte_count,
  input  logic             sign_ext,
  output logic             busy,
  output logic             done,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             inst_valid,
  output logic [31:0]      inst_data,
  input  logic             inst_ready
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COLLECT   = 3'd1,
    EMIT_LO   = 3'd2,
    EMIT_HI   = 3'd3,
    EMIT_PUSH = 3'd4,
    FINISH    = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_BYTES);
  localparam logic [3:0]       REG_F = 4'(REG);

  state_t           state, state_nxt;
  logic [31:0]      acc, acc_nxt;
  logic [CNT_W-1:0] rem, rem_nxt;
  logic [CNT_W-1:0] n_lat, n_nxt;
  logic             sgn_lat, sgn_nxt;
  logic [31:0]      inst_nxt;

  logic [CNT_W-1:0] n_eff;
  logic [31:0]      acc_shift;
  logic [31:0]      val_shift;
  logic [31:0]      val_cur;

  // Keep the low 8n bits of the accumulator and fill the rest with the
  // operand's top bit (sign) or zeros.
  function automatic logic [31:0] extend(input logic [31:0] a,
                                         input logic [CNT_W-1:0] n,
                                         input logic s);
    logic [31:0] v;
    v = a;
    if (n == CNT_W'(1))
      v = {{24{s & a[7]}}, a[7:0]};
    else if (n == CNT_W'(2))
      v = {{16{s & a[15]}}, a[15:0]};
    else if (n == CNT_W'(3))
      v = {{8{s & a[23]}}, a[23:0]};
    return v;
  endfunction

  function automatic logic [31:0] movw(input logic [31:0] v);
    return {12'hE30, v[15:12], REG_F, v[11:0]};
  endfunction

  function automatic logic [31:0] movt(input logic [31:0] v);
    return {12'hE34, v[31:28], REG_F, v[27:16]};
  endfunction

  function automatic logic [31:0] push_word();
    return {16'hE52D, REG_F, 12'h004};
  endfunction

`ifdef MVN_SHORT_EN
  // ~v fits in 8 bits exactly when v[31:8] is all ones.
  function automatic logic mvn_fits(input logic [31:0] v);
    return (v[31:8] == 24'hFFFFFF);
  endfunction

  function automatic logic [31:0] mvn(input logic [31:0] v);
    logic [31:0] nv;
    nv = ~v;
    return {12'hE3E, 4'h0, REG_F, 4'h0, nv[7:0]};
  endfunction
`endif

  assign n_eff     = (byte_count > MAX_N) ? MAX_N : byte_count;
  assign acc_shift = {acc[23:0], byte_data};
  // val_shift is the value as it will be once the byte arriving this cycle
  // is shifted in; it lets the first word be registered on the same edge.
  assign val_shift = extend(acc_shift, n_lat, sgn_lat);
  assign val_cur   = extend(acc, n_lat, sgn_lat);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= 32'h0;
      rem       <= '0;
      n_lat     <= '0;
      sgn_lat   <= 1'b0;
      inst_data <= 32'h0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      rem       <= rem_nxt;
      n_lat     <= n_nxt;
      sgn_lat   <= sgn_nxt;
      inst_data <= inst_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    rem_nxt   = rem;
    n_nxt     = n_lat;
    sgn_nxt   = sgn_lat;
    inst_nxt  = inst_data;

    case (state)
      IDLE: begin
        if (start) begin
          acc_nxt = 32'h0;
          sgn_nxt = sign_ext;
          n_nxt   = n_eff;
          rem_nxt = n_eff;
          if (n_eff == '0)
            state_nxt = FINISH;
          else
            state_nxt = COLLECT;
        end
      end

      COLLECT: begin
        if (byte_valid) begin
          acc_nxt = acc_shift;
          rem_nxt = rem - CNT_W'(1);
          if (rem == CNT_W'(1)) begin
            state_nxt = EMIT_LO;
`ifdef MVN_SHORT_EN
            inst_nxt = mvn_fits(val_shift) ? mvn(val_shift) : movw(val_shift);
`else
            inst_nxt = movw(val_shift);
`endif
          end
        end
      end

      EMIT_LO: begin
        if (inst_ready) begin
`ifdef MVN_SHORT_EN
          if (mvn_fits(val_cur) || (val_cur[31:16] == 16'h0)) begin
`else
          if (val_cur[31:16] == 16'h0) begin
`endif
            state_nxt = EMIT_PUSH;
            inst_nxt  = push_word();
          end else begin
            state_nxt = EMIT_HI;
            inst_nxt  = movt(val_cur);
          end
        end
      end

      EMIT_HI: begin
        if (inst_ready) begin
          state_nxt = EMIT_PUSH;
          inst_nxt  = push_word();
        end
      end

      EMIT_PUSH: begin
        if (inst_ready) begin
          state_nxt = FINISH;
          inst_nxt  = 32'h0;
        end
      end

      FINISH: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy       = (state == COLLECT) || (state == EMIT_LO) ||
                      (state == EMIT_HI) || (state == EMIT_PUSH);
  assign done       = (state == FINISH);
  assign byte_ready = (state == COLLECT);
  assign inst_valid = (state == EMIT_LO) || (state == EMIT_HI) ||
                      (state == EMIT_PUSH);

endmodule

// File: tb/tb_jvm_param_emitter.sv
// Directed testbench for jvm_param_emitter (REG=0, MAX_BYTES=4, CNT_W=3).
// Expected words are hand-computed; define MVN_SHORT_EN for both DUT and
// bench to select the short-MVN expectations.

module tb_jvm_param_emitter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  byte_count;
  logic        sign_ext;
  logic        busy;
  logic        done;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic        inst_ready;

  int checks = 0;
  int errors = 0;

  logic [31:0] q[$];
  int          nbytes;
  int          ndone;
  bit          br_seen;
  bit          iv_seen;

  jvm_param_emitter #(.MAX_BYTES(4), .REG(0), .CNT_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_count (byte_count),
    .sign_ext   (sign_ext),
    .busy       (busy),
    .done       (done),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .inst_valid (inst_valid),
    .inst_data  (inst_data),
    .inst_ready (inst_ready)
  );

  always #5 clk = ~clk;

  // Handshake monitor: values read at the edge are the pre-edge values.
  always @(posedge clk) begin
    if (byte_valid && byte_ready) nbytes++;
    if (inst_valid && inst_ready) q.push_back(inst_data);
    if (done) ndone++;
    if (byte_ready) br_seen = 1'b1;
    if (inst_valid) iv_seen = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    q.delete();
    nbytes  = 0;
    ndone   = 0;
    br_seen = 1'b0;
    iv_seen = 1'b0;
  endtask

  task automatic do_start(input logic [2:0] n, input logic s);
    start      = 1'b1;
    byte_count = n;
    sign_ext   = s;
    tick();
    start      = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ok);
    ok         = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (byte_ready) ok = 1'b1;
      tick();
    end
    byte_valid = 1'b0;
    byte_data  = 8'h00;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (done) ok = 1'b1;
      else tick();
    end
  endtask

  // bytes[7:0] is sent first. Returns in IDLE, one cycle after FINISH.
  task automatic run_txn(input logic [2:0] n, input logic s,
                         input logic [31:0] bytes, output bit ok);
    bit b_ok;
    int k;
    ok = 1'b1;
    do_start(n, s);
    k = (n > 3'd4) ? 4 : int'(n);
    for (int i = 0; i < k; i++) begin
      send_byte(bytes[8*i +: 8], b_ok);
      if (!b_ok) ok = 1'b0;
    end
    wait_done(b_ok);
    if (!b_ok) ok = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    start      = 1'b0;
    byte_count = 3'd0;
    sign_ext   = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    inst_ready = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy, done, byte_ready, inst_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000", {busy, done, byte_ready, inst_valid});
    end
    checks++;
    if (inst_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_inst_data got %h want 00000000", inst_data);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_byte();
    bit ok;
    clear_mon();
    do_start(3'd1, 1'b1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy got %b want 1", busy);
    end
    send_byte(8'h05, ok);
    wait_done(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_timeout got no done want done");
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_busy_at_done got %b want 0", busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || ndone != 1) begin
      errors++;
      $display("FAIL single_done_pulse got done=%b count=%0d want 0/1", done, ndone);
    end
    checks++;
    if (q.size() != 2 || q[0] !== 32'hE3000005 || q[1] !== 32'hE52D0004) begin
      errors++;
      $display("FAIL single_words got n=%0d %h %h want 2 E3000005 E52D0004", q.size(), q[0], q[1]);
    end
    checks++;
    if (nbytes != 1) begin
      errors++;
      $display("FAIL single_bytes got %0d want 1", nbytes);
    end
  endtask

  task automatic test_zero_ext_two();
    bit ok;
    clear_mon();
    run_txn(3'd2, 1'b0, 32'h0000_3412, ok);
    checks++;
    if (!ok || q.size() != 2 || q[0] !== 32'hE3010234 || q[1] !== 32'hE52D0004) begin
      errors++;
      $display("FAIL zext2 got ok=%b n=%0d %h %h want 1 2 E3010234 E52D0004", ok, q.size(), q[0], q[1]);
    end
  endtask

  task automatic test_sign_ext_movt();
    bit ok;
    clear_mon();
    run_txn(3'd2, 1'b1, 32'h0000_38FF, ok);
`ifdef MVN_SHORT_EN
    checks++;
    if (!ok || q.size() != 2 || q[0] !== 32'hE3E000C7 || q[1] !== 32'hE52D0004) begin
      errors++;
      $display("FAIL sext2_mvn got ok=%b n=%0d %h %h want 1 2 E3E000C7 E52D0004", ok, q.size(), q[0], q[1]);
    end
`else
    checks++;
    if (!ok || q.size() != 3 || q[0] !== 32'hE30F0F38 || q[1] !== 32'hE34F0FFF || q[2] !== 32'hE52D0004) begin
      errors++;
      $display("FAIL sext2_movt got ok=%b n=%0d %h %h %h want 1 3 E30F0F38 E34F0FFF E52D0004",
               ok, q.size(), q[0], q[1], q[2]);
    end
`endif
  endtask

  task automatic test_three_byte();
    bit ok;
    clear_mon();
    run_txn(3'd3, 1'b1, 32'h0001_0080, ok);
    checks++;
    if (!ok || q.size() != 3 || q[0] !== 32'hE3000001 || q[1] !== 32'hE34F0F80 || q[2] !== 32'hE52D0004) begin
      errors++;
      $display("FAIL sext3 got ok=%b n=%0d %h %h %h want 1 3 E3000001 E34F0F80 E52D0004",
               ok, q.size(), q[0], q[1], q[2]);
    end
  endtask

  task automatic test_zero_count();
    clear_mon();
    byte_valid = 1'b1;
    byte_data  = 8'h55;
    do_start(3'd0, 1'b0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_done got done=%b busy=%b want 1/0", done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL zero_done_pulse got %b want 0", done);
    end
    tick();
    tick();
    byte_valid = 1'b0;
    checks++;
    if (nbytes != 0 || br_seen || iv_seen || q.size() != 0 || ndone != 1) begin
      errors++;
      $display("FAIL zero_quiet got bytes=%0d br=%b iv=%b words=%0d dones=%0d want 0 0 0 0 1",
               nbytes, br_seen, iv_seen, q.size(), ndone);
    end
  endtask

  task automatic test_saturate();
    bit ok;
    clear_mon();
    byte_valid = 1'b1;
    byte_data  = 8'h01;
    do_start(3'd7, 1'b0);
    wait_done(ok);
    byte_valid = 1'b0;
    tick();
    checks++;
    if (!ok || nbytes != 4) begin
      errors++;
      $display("FAIL sat_bytes got ok=%b bytes=%0d want 1 4", ok, nbytes);
    end
    checks++;
    if (q.size() != 3 || q[0] !== 32'hE3000101 || q[1] !== 32'hE3400101 || q[2] !== 32'hE52D0004) begin
      errors++;
      $display("FAIL sat_words got n=%0d %h %h %h want 3 E3000101 E3400101 E52D0004",
               q.size(), q[0], q[1], q[2]);
    end
  endtask

  task automatic test_stall();
    bit ok;
    bit seen;
    clear_mon();
    inst_ready = 1'b0;
    do_start(3'd1, 1'b1);
    send_byte(8'h7F, ok);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (inst_valid) seen = 1'b1;
      else tick();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL stall_timeout got no inst_valid want inst_valid");
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (inst_valid !== 1'b1 || inst_data !== 32'hE300007F) begin
        errors++;
        $display("FAIL stall_hold cycle %0d got v=%b %h want 1 E300007F", i, inst_valid, inst_data);
      end
      tick();
    end
    inst_ready = 1'b1;
    wait_done(ok);
    tick();
    checks++;
    if (!ok || q.size() != 2 || q[0] !== 32'hE300007F || q[1] !== 32'hE52D0004) begin
      errors++;
      $display("FAIL stall_words got ok=%b n=%0d %h %h want 1 2 E300007F E52D0004", ok, q.size(), q[0], q[1]);
    end
  endtask

  task automatic test_byte_toggle();
    bit ok;
    bit ok2;
    clear_mon();
    do_start(3'd2, 1'b0);
    byte_valid = 1'b0;
    byte_data  = 8'hEE;
    tick();
    start      = 1'b1;
    byte_count = 3'd1;
    sign_ext   = 1'b1;
    tick();
    start      = 1'b0;
    send_byte(8'hAB, ok);
    byte_valid = 1'b0;
    byte_data  = 8'h77;
    tick();
    send_byte(8'hCD, ok2);
    wait_done(ok);
    tick();
    checks++;
    if (!ok || !ok2 || nbytes != 2) begin
      errors++;
      $display("FAIL toggle_bytes got ok=%b/%b bytes=%0d want 1/1 2", ok, ok2, nbytes);
    end
    checks++;
    if (q.size() != 2 || q[0] !== 32'hE30A0BCD || q[1] !== 32'hE52D0004) begin
      errors++;
      $display("FAIL toggle_words got n=%0d %h %h want 2 E30A0BCD E52D0004", q.size(), q[0], q[1]);
    end
  endtask

  task automatic test_reset_abort();
    bit ok;
    clear_mon();
    do_start(3'd2, 1'b0);
    send_byte(8'h99, ok);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, byte_ready, inst_valid} !== 4'b0000 || inst_data !== 32'h0) begin
      errors++;
      $display("FAIL abort_outputs got %b %h want 0000 00000000",
               {busy, done, byte_ready, inst_valid}, inst_data);
    end
    reset = 1'b0;
    tick();
    clear_mon();
    run_txn(3'd1, 1'b0, 32'h0000_0007, ok);
    checks++;
    if (!ok || q.size() != 2 || q[0] !== 32'hE3000007 || q[1] !== 32'hE52D0004) begin
      errors++;
      $display("FAIL abort_next got ok=%b n=%0d %h %h want 1 2 E3000007 E52D0004", ok, q.size(), q[0], q[1]);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit ok2;
    clear_mon();
    run_txn(3'd1, 1'b0, 32'h0000_0080, ok);
    run_txn(3'd1, 1'b1, 32'h0000_0080, ok2);
`ifdef MVN_SHORT_EN
    checks++;
    if (!ok || !ok2 || q.size() != 4 || q[0] !== 32'hE3000080 || q[1] !== 32'hE52D0004 ||
        q[2] !== 32'hE3E0007F || q[3] !== 32'hE52D0004) begin
      errors++;
      $display("FAIL b2b got ok=%b/%b n=%0d %h %h %h %h want 4 E3000080 E52D0004 E3E0007F E52D0004",
               ok, ok2, q.size(), q[0], q[1], q[2], q[3]);
    end
`else
    checks++;
    if (!ok || !ok2 || q.size() != 5 || q[0] !== 32'hE3000080 || q[1] !== 32'hE52D0004 ||
        q[2] !== 32'hE30F0F80 || q[3] !== 32'hE34F0FFF || q[4] !== 32'hE52D0004) begin
      errors++;
      $display("FAIL b2b got ok=%b/%b n=%0d %h %h %h %h %h want 5 E3000080 E52D0004 E30F0F80 E34F0FFF E52D0004",
               ok, ok2, q.size(), q[0], q[1], q[2], q[3], q[4]);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_zero_ext_two();
    test_sign_ext_movt();
    test_three_byte();
    test_zero_count();
    test_saturate();
    test_stall();
    test_byte_toggle();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
